// File: rtl/seq_somador_dr.sv
// Sequencer for a 4-bit dual-rail ripple adder. It takes single-rail operands in, runs one
// evaluate/spacer cycle on the adder, and returns the decoded sum over a valid/ready handshake.
module seq_somador_dr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  input  logic       op_cin,
  output logic [7:0] dr_a,
  output logic [7:0] dr_b,
  output logic [1:0] dr_cin,
  input  logic [7:0] dr_soma,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] result,
  output logic       err
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_NULL, S_HOLD} state_t;

  // Counter value seen on the TIMEOUT-th cycle of a phase (counter starts at 0 on entry).
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [7:0] dr_a_reg, dr_a_next;
  logic [7:0] dr_b_reg, dr_b_next;
  logic [1:0] dr_cin_reg, dr_cin_next;
  logic [3:0] result_reg, result_next;
  logic       err_reg, err_next;

  logic [3:0] pair_true;
  logic [3:0] pair_illegal;
  logic [3:0] pair_complete;
  logic       all_complete;
  logic       any_illegal;
  logic       soma_null;
  logic       timeout_hit;

  function automatic logic [7:0] encode4(input logic [3:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pair
      assign pair_true[gi]     = dr_soma[2*gi+1];
      assign pair_illegal[gi]  = dr_soma[2*gi+1] & dr_soma[2*gi];
      assign pair_complete[gi] = dr_soma[2*gi+1] ^ dr_soma[2*gi];
    end
  endgenerate

  assign all_complete = &pair_complete;
  assign any_illegal  = |pair_illegal;
  assign soma_null    = (dr_soma == 8'h00);
  assign timeout_hit  = (cnt_reg == LAST_CNT);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    dr_a_next   = dr_a_reg;
    dr_b_next   = dr_b_reg;
    dr_cin_next = dr_cin_reg;
    result_next = result_reg;
    err_next    = err_reg;
    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          dr_a_next   = encode4(op_a);
          dr_b_next   = encode4(op_b);
          dr_cin_next = {op_cin, ~op_cin};
          result_next = 4'h0;
          err_next    = 1'b0;
          state_next  = S_EVAL;
        end
      end
      S_EVAL: begin
        cnt_next = cnt_reg + 8'd1;
        // An illegal 11 pair wins over completion; illegal bits read back as 0.
        if (any_illegal) begin
          result_next = pair_true & ~pair_illegal;
          err_next    = 1'b1;
          state_next  = S_NULL;
        end else if (all_complete) begin
          result_next = pair_true;
          err_next    = 1'b0;
          state_next  = S_NULL;
        end else if (timeout_hit) begin
          result_next = 4'h0;
          err_next    = 1'b1;
          state_next  = S_NULL;
        end
        if (state_next == S_NULL) begin
          dr_a_next   = 8'h00;
          dr_b_next   = 8'h00;
          dr_cin_next = 2'b00;
        end
      end
      S_NULL: begin
        cnt_next = cnt_reg + 8'd1;
        if (soma_null) begin
          state_next = S_HOLD;
        end else if (timeout_hit) begin
          err_next   = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (state_next != state_reg) cnt_next = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= 8'd0;
      dr_a_reg   <= 8'h00;
      dr_b_reg   <= 8'h00;
      dr_cin_reg <= 2'b00;
      result_reg <= 4'h0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      dr_a_reg   <= dr_a_next;
      dr_b_reg   <= dr_b_next;
      dr_cin_reg <= dr_cin_next;
      result_reg <= result_next;
      err_reg    <= err_next;
    end
  end

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_HOLD);
  assign dr_a      = dr_a_reg;
  assign dr_b      = dr_b_reg;
  assign dr_cin    = dr_cin_reg;
  assign result    = result_reg;
  assign err       = err_reg;

endmodule

// File: doc/seq_somador_dr.md
# seq_somador_dr

Clocked sequencer that drives and collects one transaction through the 4-bit dual-rail ripple adder. It accepts single-rail operands over a valid/ready handshake and encodes them onto the adder's dual-rail operand inputs. It detects completion on the dual-rail sum, then drives the spacer (all-zero) phase and waits for the sum to return to zero. It presents the decoded 4-bit sum downstream over a second valid/ready handshake.

## Interface
Parameters:
- TIMEOUT, 15, max cycles spent in either evaluation or spacer phase before declaring error (range 2..255)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand request
- in_ready  out  1  high when block can accept operands
- op_a  in  4  operand A, single-rail
- op_b  in  4  operand B, single-rail
- op_cin  in  1  carry-in, single-rail
- dr_a  out  8  operand A, dual-rail; bit i on [2i+1] (true rail) / [2i] (false rail)
- dr_b  out  8  operand B, dual-rail, same packing
- dr_cin  out  2  carry-in, [1] true / [0] false
- dr_soma  in  8  dual-rail sum from adder, same packing
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- result  out  4  decoded sum (carry-out discarded, mod 16)
- err  out  1  transaction error flag, qualified by out_valid

## Operation
- Dual-rail encoding: 1 = {t,f}=10, 0 = 01, spacer = 00, 11 = illegal.
- Pair state: complete = exactly one rail high; null = both low.
- FSM states: IDLE, EVAL, NULL, HOLD.
- IDLE: in_ready=1; all dr_* outputs 00. On in_valid: register encoded op_a/op_b/op_cin onto dr_a/dr_b/dr_cin, clear phase counter, go EVAL.
- EVAL: hold encoded rails.
  - All 4 dr_soma pairs complete → result[i] = dr_soma[2i+1], err = 0, go NULL.
  - Any pair 11 → result[i] = 0 for each illegal pair, err = 1, go NULL. Illegal code takes priority over completion.
  - Counter reaches TIMEOUT with no completion → result = 0, err = 1, go NULL.
- NULL: dr_* outputs 00.
  - All dr_soma bits 0 → go HOLD.
  - TIMEOUT cycles without reaching zero → err = 1, go HOLD.
- HOLD: out_valid = 1; result and err held stable. On out_ready → go IDLE.
- Phase counter: 8-bit; cleared on every state entry; increments each cycle in EVAL and NULL.
- dr_soma is combinational from this block's registered rails. It is sampled directly, with no synchronizer.

## Timing
- Reset: state IDLE; dr_a=dr_b=0x00, dr_cin=00, out_valid=0, result=0x0, err=0; in_ready=1 from first cycle after rst deasserts.
- rst in any state (including mid-EVAL/NULL/HOLD) aborts the transaction. The pending result is dropped and the next cycle shows reset values.
- in_ready = (state==IDLE); out_valid = (state==HOLD); all dr_* outputs registered.
- Accept at edge N (in_valid & in_ready) → rails valid in cycle N+1.
- With a combinational adder: capture at end of N+1; rails 00 in N+2; out_valid=1 in N+3.
- Minimum latency is 3 cycles from accept to out_valid. Minimum issue interval is 4 cycles (out_ready held high).
- Timeout fires on the TIMEOUT-th cycle of a phase without its exit condition. Worst-case latency = 2·TIMEOUT + 1.
- out_valid held with result/err stable while out_ready=0. No new operand is accepted until the HOLD handshake completes.
- op_* are ignored outside IDLE.

## Test plan
- op_a=0x3, op_b=0x5, op_cin=0, behavioural adder → dr_a=0x5A, dr_b=0x66, dr_cin=01 in cycle N+1; dr_* = 0 in N+2; out_valid in N+3 with result=0x8, err=0.
- op_a=0xF, op_b=0x1, op_cin=1 → result=0x1 (wrap, carry dropped), err=0; exhaustive 512-combination sweep against (a+b+cin) mod 16.
- out_ready low for 5 cycles in HOLD → result/err/out_valid stable, in_ready=0, dr_*=0 throughout; IDLE one cycle after out_ready rises.
- Adder model with dr_soma stuck at 0x00, TIMEOUT=15 → EVAL exits after 15 cycles; result=0x0, err=1; then NULL completes immediately.
- dr_soma forced 0x5B (pair 0 = 11) during EVAL → result bit 0 = 0, err=1. Adder model holding dr_soma nonzero in NULL → err=1 after TIMEOUT cycles.
- rst asserted one cycle into EVAL → next cycle all rails 00, out_valid=0, in_ready=1. A fresh transaction 0x7+0x7+0 then yields result=0xE.
